// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter: shares the system memory bus between the 6502 core and the
// video fetch unit. The CPU owns the bus by default. A video request first pulls
// BA low for WARN_CYCLES cycles, then hands the bus to video. The bus comes back
// to the CPU through a one-cycle turnaround. Stolen cycles are counted, and a
// sticky flag records any forced release.
module c64_bus_arbiter #(
  parameter int WARN_CYCLES = 3,   // 1..7
  parameter int MAX_GRANT   = 40   // 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  input  logic        vid_req,
  input  logic [15:0] vid_ab,
  input  logic        stat_clr,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_do,
  output logic        mem_we,
  output logic        cpu_rdy,
  output logic        ba,
  output logic        aec,
  output logic        vid_ack,
  output logic [15:0] stolen_cycles,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, WARN, GRANT, RELEASE} state_t;

  localparam logic [2:0] WARN_INIT  = 3'(WARN_CYCLES - 1);
  localparam logic [7:0] GRANT_LAST = 8'(MAX_GRANT - 1);

  state_t      state, state_nxt;
  logic [2:0]  warn_cnt, warn_cnt_nxt;
  logic [7:0]  grant_cnt, grant_cnt_nxt;
  logic [15:0] stolen_nxt;
  logic        overrun_nxt;

  // The stolen-cycle counter sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state logic, counters and statistics; a stat clear overrides any increment.
  always_comb begin
    state_nxt     = state;
    warn_cnt_nxt  = warn_cnt;
    grant_cnt_nxt = grant_cnt;
    stolen_nxt    = stolen_cycles;
    overrun_nxt   = overrun;
    case (state)
      IDLE: begin
        if (vid_req) begin
          state_nxt    = WARN;
          warn_cnt_nxt = WARN_INIT;
        end
      end
      WARN: begin
        if (!vid_req) begin
          state_nxt = IDLE;
        end else if (warn_cnt == 3'd0) begin
          state_nxt     = GRANT;
          grant_cnt_nxt = 8'd0;
        end else begin
          warn_cnt_nxt = warn_cnt - 3'd1;
        end
      end
      GRANT: begin
        if (!vid_req) begin
          state_nxt = RELEASE;
        end else begin
          grant_cnt_nxt = grant_cnt + 8'd1;
          stolen_nxt    = sat_inc(stolen_cycles);
          if (grant_cnt == GRANT_LAST) begin
            state_nxt   = RELEASE;
            overrun_nxt = 1'b1;
          end
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stat_clr) begin
      stolen_nxt  = 16'd0;
      overrun_nxt = 1'b0;
    end
  end

  // State, counters and statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      warn_cnt      <= 3'd0;
      grant_cnt     <= 8'd0;
      stolen_cycles <= 16'd0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      warn_cnt      <= warn_cnt_nxt;
      grant_cnt     <= grant_cnt_nxt;
      stolen_cycles <= stolen_nxt;
      overrun       <= overrun_nxt;
    end
  end

  // Bus control decode and the unregistered address/data mux.
  always_comb begin
    mem_ab  = cpu_ab;
    mem_do  = cpu_do;
    mem_we  = cpu_we;
    cpu_rdy = 1'b1;
    ba      = 1'b1;
    aec     = 1'b1;
    vid_ack = 1'b0;
    case (state)
      IDLE: ;
      WARN: begin
        ba      = 1'b0;
        cpu_rdy = 1'b0;
      end
      GRANT: begin
        aec     = 1'b0;
        ba      = 1'b0;
        cpu_rdy = 1'b0;
        mem_ab  = vid_ab;
        mem_do  = 8'h00;
        mem_we  = 1'b0;
        vid_ack = vid_req;
      end
      RELEASE: begin
        cpu_rdy = 1'b0;
        mem_we  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Scoreboard bench for c64_bus_arbiter: a driver applies randomized and directed
// stimulus and pushes the expected bus outputs for each cycle; a monitor pops and
// compares on the falling edge.
module tb_c64_bus_arbiter;

  localparam int WARN_CYCLES = 3;
  localparam int MAX_GRANT   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_ab = 16'h0;
  logic [7:0]  cpu_do = 8'h0;
  logic        cpu_we = 1'b0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_ab = 16'h0;
  logic        stat_clr = 1'b0;
  logic [15:0] mem_ab;
  logic [7:0]  mem_do;
  logic        mem_we, cpu_rdy, ba, aec, vid_ack, overrun;
  logic [15:0] stolen_cycles;

  c64_bus_arbiter #(.WARN_CYCLES(WARN_CYCLES), .MAX_GRANT(MAX_GRANT)) dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .vid_req(vid_req), .vid_ab(vid_ab), .stat_clr(stat_clr),
    .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .cpu_rdy(cpu_rdy),
    .ba(ba), .aec(aec), .vid_ack(vid_ack), .stolen_cycles(stolen_cycles),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we, rdy, ba, aec, ack, ovr;
    logic [15:0] stolen;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: who owns the bus, and how far into the current phase we are.
  localparam int M_CPU = 0, M_WARN = 1, M_VIDEO = 2, M_TURN = 3;
  int m_mode = M_CPU;
  int m_warned = 0;
  int m_granted = 0;
  int m_stolen = 0;
  bit m_ovr = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_CPU; m_warned = 0; m_granted = 0; m_stolen = 0; m_ovr = 0;
  endtask

  // One clock edge of the bus-sharing rules, given what was sampled at that edge.
  task automatic model_step(input logic req, input logic clr);
    case (m_mode)
      M_CPU:  if (req) begin m_mode = M_WARN; m_warned = 0; end
      M_WARN: begin
        if (!req) m_mode = M_CPU;
        else if (m_warned + 1 == WARN_CYCLES) begin m_mode = M_VIDEO; m_granted = 0; end
        else m_warned++;
      end
      M_VIDEO: begin
        if (!req) m_mode = M_TURN;
        else begin
          m_granted++;
          if (m_stolen < 65535) m_stolen++;
          if (m_granted == MAX_GRANT) begin m_mode = M_TURN; m_ovr = 1; end
        end
      end
      default: m_mode = M_CPU;
    endcase
    if (clr) begin m_stolen = 0; m_ovr = 0; end
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.ab = cpu_ab; e.dout = cpu_do; e.we = cpu_we;
    e.rdy = 1; e.ba = 1; e.aec = 1; e.ack = 0;
    e.stolen = 16'(m_stolen); e.ovr = m_ovr;
    case (m_mode)
      M_WARN:  begin e.ba = 0; e.rdy = 0; end
      M_VIDEO: begin
        e.aec = 0; e.ba = 0; e.rdy = 0; e.ab = vid_ab; e.dout = 8'h00;
        e.we = 0; e.ack = vid_req;
      end
      M_TURN:  begin e.rdy = 0; e.we = 0; end
      default: ;
    endcase
    return e;
  endfunction

  // Advance one cycle with fully specified inputs.
  task automatic cyc_full(input logic rq, input logic [15:0] cab, input logic [7:0] cdo,
                          input logic cwe, input logic clr, input logic rstv);
    @(posedge clk); #1;
    if (reset) model_step(vid_req, stat_clr);
    vid_req = rq; cpu_ab = cab; cpu_do = cdo; cpu_we = cwe;
    vid_ab = 16'($urandom); stat_clr = clr; reset = rstv;
    if (!rstv) model_reset();
    sb.push_back(expected());
  endtask

  task automatic cyc(input logic rq, input logic clr, input logic rstv);
    cyc_full(rq, 16'($urandom), 8'($urandom), 1'($urandom), clr, rstv);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mem_ab", mem_ab, e.ab);
      chk("mem_do", 16'(mem_do), 16'(e.dout));
      chk("mem_we", 16'(mem_we), 16'(e.we));
      chk("cpu_rdy", 16'(cpu_rdy), 16'(e.rdy));
      chk("ba", 16'(ba), 16'(e.ba));
      chk("aec", 16'(aec), 16'(e.aec));
      chk("vid_ack", 16'(vid_ack), 16'(e.ack));
      chk("stolen_cycles", stolen_cycles, e.stolen);
      chk("overrun", 16'(overrun), 16'(e.ovr));
    end
  end

  initial begin
    #980000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rq;
    rq = 0;
    // Reset, then release.
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);

    // Basic steal: request held six cycles, then dropped.
    for (int i = 0; i < 6; i++) cyc(1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    // Abort during warning, with a CPU write to D020 passing through.
    cyc(1, 0, 1);
    cyc_full(0, 16'hD020, 8'h0E, 1'b1, 1'b0, 1'b1);
    cyc_full(0, 16'hD020, 8'h0E, 1'b1, 1'b0, 1'b1);
    cyc(0, 0, 1);

    // Forced release: hold the request well beyond MAX_GRANT.
    for (int i = 0; i < MAX_GRANT + 20; i++) cyc(1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    cyc(0, 1, 1);

    // Reset mid-grant, released with the request still high.
    for (int i = 0; i < 6; i++) cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = ~rq;
      cyc(rq, ($urandom_range(0, 63) == 0), !($urandom_range(0, 399) == 0));
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);

    // Saturation: clear, then steal until the counter pins at FFFF.
    cyc(0, 1, 1);
    for (int i = 0; i < 80000 && m_stolen != 65535; i++) cyc(1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1);
    for (int i = 0; i < 60 && m_mode != M_VIDEO; i++) cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 1);   // clear coincides with a grant increment
    cyc(1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    @(negedge clk); #1;
    chk("queue_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
